// File: rtl/dpa_pkg.sv
// Shared constants, flag bundle and helper for the dpa arithmetic blocks.
package dpa_pkg;

  localparam int DPA_N     = 64;
  localparam int DPA_SLICE = 16;

  typedef struct packed {
    logic bout;
    logic negative;
    logic overflow;
    logic zero;
  } dpa_flags_t;

  // Signed overflow of a - b: operands differ in sign and the result sign left a's sign.
  function automatic logic dpa_signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/dpa_sub_slice.sv
// Combinational SLICE-bit ripple subtractor: d_s = a_s + ~b_s + cin, cout is the carry out.
module dpa_sub_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             cin,
  output logic [SLICE-1:0] d_s,
  output logic             cout
);

  logic [SLICE:0]   w_c;
  logic [SLICE-1:0] w_nb;

  assign w_nb   = ~b_s;
  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
      assign d_s[gi]    = a_s[gi] ^ w_nb[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (a_s[gi] & w_nb[gi]) | (w_c[gi] & (a_s[gi] ^ w_nb[gi]));
    end
  endgenerate

  assign cout = w_c[SLICE];

endmodule

// File: rtl/dpa_sub_pipe.sv
// Pipelined N-bit subtractor (diff = a - b - bin) with one SLICE-wide borrow segment per stage,
// valid/ready on both sides and registered status flags.
module dpa_sub_pipe
  import dpa_pkg::*;
#(
  parameter int N     = DPA_N,
  parameter int SLICE = DPA_SLICE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  input  logic         signed_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         negative_flag,
  output logic         overflow_flag,
  output logic         zero_flag
);

  localparam int STAGES = N / SLICE;

  generate
    // A single-slice build has no borrow chain to split; use the combinational adder instead.
    if ((N % SLICE) != 0 || STAGES < 2) begin : g_param_check
      $error("dpa_sub_pipe: N must be a multiple of SLICE with at least two slices");
    end
  endgenerate

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_src_v;

  logic [N-1:0] r_diff  [STAGES];
  logic [N-1:0] r_a     [STAGES-1];
  logic [N-1:0] r_b     [STAGES-1];
  logic         r_carry [STAGES-1];
  logic         r_amsb  [STAGES-1];
  logic         r_bmsb  [STAGES-1];
  logic         r_sen   [STAGES-1];
  dpa_flags_t   r_flags;

  logic [N-1:0]     w_a_src    [STAGES];
  logic [N-1:0]     w_b_src    [STAGES];
  logic [N-1:0]     w_diff_new [STAGES];
  logic [SLICE-1:0] w_d_s      [STAGES];
  logic             w_cin      [STAGES];
  logic             w_cout     [STAGES];
  logic             w_amsb     [STAGES];
  logic             w_bmsb     [STAGES];
  logic             w_sen      [STAGES];

  logic [N-1:0] w_fin_diff;
  dpa_flags_t   w_flags_next;

  assign w_src_v = {r_valid[STAGES-2:0], in_valid};

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // A stage can load whenever it or any stage downstream of it holds a bubble, or the sink is taking.
      assign w_load[gi] = out_ready | ~(&r_valid[STAGES-1:gi]);

      if (gi == 0) begin : g_head
        assign w_a_src[gi]    = a;
        assign w_b_src[gi]    = b;
        assign w_cin[gi]      = ~bin;
        assign w_amsb[gi]     = a[N-1];
        assign w_bmsb[gi]     = b[N-1];
        assign w_sen[gi]      = signed_en;
        assign w_diff_new[gi] = {w_d_s[gi], {(N-SLICE){1'b0}}};
      end else begin : g_body
        assign w_a_src[gi]    = r_a[gi-1];
        assign w_b_src[gi]    = r_b[gi-1];
        assign w_cin[gi]      = r_carry[gi-1];
        assign w_amsb[gi]     = r_amsb[gi-1];
        assign w_bmsb[gi]     = r_bmsb[gi-1];
        assign w_sen[gi]      = r_sen[gi-1];
        // Finished slices shift down so slice 0 lands at the bottom after the last stage.
        assign w_diff_new[gi] = {w_d_s[gi], r_diff[gi-1][N-1:SLICE]};
      end

      dpa_sub_slice #(
        .SLICE (SLICE)
      ) u_slice (
        .a_s  (w_a_src[gi][SLICE-1:0]),
        .b_s  (w_b_src[gi][SLICE-1:0]),
        .cin  (w_cin[gi]),
        .d_s  (w_d_s[gi]),
        .cout (w_cout[gi])
      );
    end
  endgenerate

  assign w_fin_diff            = w_diff_new[STAGES-1];
  assign w_flags_next.bout     = ~w_cout[STAGES-1];
  assign w_flags_next.negative = w_sen[STAGES-1] & w_fin_diff[N-1];
  assign w_flags_next.overflow = w_sen[STAGES-1]
                               ? dpa_signed_ovf(w_amsb[STAGES-1], w_bmsb[STAGES-1], w_fin_diff[N-1])
                               : ~w_cout[STAGES-1];
  assign w_flags_next.zero     = (w_fin_diff == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_flags <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_diff[k] <= '0;
      end
      for (int k = 0; k < STAGES-1; k++) begin
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_carry[k] <= 1'b0;
        r_amsb[k]  <= 1'b0;
        r_bmsb[k]  <= 1'b0;
        r_sen[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= w_src_v[k];
        end
        if (w_load[k] && w_src_v[k]) begin
          r_diff[k] <= w_diff_new[k];
        end
      end
      for (int k = 0; k < STAGES-1; k++) begin
        if (w_load[k] && w_src_v[k]) begin
          r_a[k]     <= w_a_src[k] >> SLICE;
          r_b[k]     <= w_b_src[k] >> SLICE;
          r_carry[k] <= w_cout[k];
          r_amsb[k]  <= w_amsb[k];
          r_bmsb[k]  <= w_bmsb[k];
          r_sen[k]   <= w_sen[k];
        end
      end
      if (w_load[STAGES-1] && w_src_v[STAGES-1]) begin
        r_flags <= w_flags_next;
      end
    end
  end

  assign in_ready      = w_load[0];
  assign out_valid     = r_valid[STAGES-1];
  assign diff          = r_diff[STAGES-1];
  assign bout          = r_flags.bout;
  assign negative_flag = r_flags.negative;
  assign overflow_flag = r_flags.overflow;
  assign zero_flag     = r_flags.zero;

endmodule
